pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Stall, flush and forwarding controller for the 5-stage MIPS pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enables and bubble/flush controls. It detects load-use and branch hazards, freezes the pipeline while a data-memory access is outstanding, and selects EX-stage operand forwarding. A watchdog halts the pipeline if memory never responds.

## Interface
- `TIMEOUT`, 64: maximum consecutive cycles in MEMWAIT before HALT; legal range 2..65535.
- `clk` in 1: pipeline clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `idRs`, `idRt` in 5: source register fields of the instruction in ID.
- `idUsesRt` in 1: the ID instruction reads rt.
- `exRs`, `exRt` in 5: source register fields in EX.
- `exRd` in 5: destination register in EX.
- `exRegWrite`, `exMemRead` in 1: EX instruction writes a register / is a load.
- `memRd` in 5, `memRegWrite` in 1: destination register and write flag in MEM.
- `wbRd` in 5, `wbRegWrite` in 1: destination register and write flag in WB.
- `branchTaken` in 1: branch in EX resolved taken.
- `memReq` in 1: the MEM-stage instruction accesses data memory.
- `memReady` in 1: data memory completes the access this cycle.
- `pcWrite`, `ifidWrite`, `idexWrite`, `exmemWrite`, `memwbWrite` out 1: register write-enables.
- `ifidFlush`, `idexFlush`, `memwbFlush` out 1: load a bubble (all control bits 0) on the next edge.
- `forwardA`, `forwardB` out 2: EX operand select. 00 selects the register file, 10 selects EX/MEM, 01 selects MEM/WB.
- `memError` out 1: high while in HALT.
- `stallCycles` out 16: saturating count of stalled cycles.

## Operation
- State register has three states: RUN, MEMWAIT, HALT. The reset value is RUN.
- Wait counter `waitCnt` is 16 bits with reset value 0. `stallCycles` resets to 0.
- All control outputs are combinational from the current state and current inputs.
- Hazard conditions (any register compare against 0 never matches):
  - **memStall**: `memReq` is high and `memReady` is low.
  - **loadUse**: `exMemRead` and `exRegWrite` are high, and `exRd` matches `idRs`, or matches `idRt` with `idUsesRt` high.
- **RUN**, priority from highest to lowest:
  1. memStall:
     - `pcWrite`, `ifidWrite`, `idexWrite` and `exmemWrite` are 0.
     - `memwbWrite` is 1 and `memwbFlush` is 1.
     - Next state is MEMWAIT; `waitCnt` is set to 1.
  2. branchTaken:
     - All write-enables are 1.
     - `ifidFlush` is 1 and `idexFlush` is 1.
  3. loadUse:
     - `pcWrite` and `ifidWrite` are 0.
     - `idexFlush` is 1.
     - All other write-enables are 1.
  4. No hazard: all write-enables are 1 and all flushes are 0.
- **MEMWAIT**:
  - If `memReady` is low: the freeze pattern from RUN rule 1 applies and `waitCnt` increments.
    - When `waitCnt` equals TIMEOUT-1, the next state is HALT.
  - If `memReady` is high: RUN rules 2-4 apply, the next state is RUN, and `waitCnt` clears to 0.
- **HALT**:
  - All write-enables are 0 and all flushes are 0.
  - `memError` is 1.
  - The block leaves HALT only on reset.
- Forwarding is evaluated in every state:
  - `forwardA` is 10 when `memRegWrite` is high and `memRd` equals `exRs`.
  - Otherwise it is 01 when `wbRegWrite` is high and `wbRd` equals `exRs`.
  - Otherwise it is 00.
  - `forwardB` follows the same rules using `exRt`.
  - The EX/MEM match wins when both stages match.
- `stallCycles` increments on every cycle where `pcWrite` is 0 in RUN or MEMWAIT. It saturates at 0xFFFF and does not count in HALT.

## Timing
- Stall and flush signals take effect at the same edge at which they are asserted.
- A load-use hazard costs exactly 1 bubble cycle.
- A taken branch costs 2 flushed slots.
- A memory access that completes N cycles after `memReq` rises costs N frozen cycles. `memReady` high in the same cycle as `memReq` costs 0 cycles.
- A branchTaken raised during MEMWAIT is held by the frozen EX stage. It is acted on in the cycle `memReady` is high.
- Reset asserted in any state:
  - State immediately becomes RUN, and `waitCnt` and `stallCycles` become 0.
  - Outputs then reflect RUN decoding of the current inputs.
- The register file writes before it reads, so WB-to-ID dependencies need neither a stall nor forwarding.

## Configuration
- Macro: `HAZARD_FORWARDING_EN`.
- When defined, the block behaves as described above.
- When undefined:
  - `forwardA` and `forwardB` are tied to 00.
  - loadUse is replaced by rawStall. rawStall is high when an ID source register (`idRs`, or `idRt` with `idUsesRt` high) matches `exRd` with `exRegWrite` high, or matches `memRd` with `memRegWrite` high.
  - rawStall takes the same priority slot and uses the same stall pattern as loadUse.
  - A dependency on an immediately preceding ALU instruction costs 2 bubbles.

## Test plan
- **Load-use**: load `$t0` in EX and `add $t1,$t0,$t2` in ID, with `exMemRead`=1 and `exRd`=8, `idRs`=8.
  - Expect one cycle with `pcWrite`=0, `ifidWrite`=0 and `idexFlush`=1.
  - The next cycle returns to all-enables, and `stallCycles`=1.
- **Forwarding priority**: `memRd`=`wbRd`=`exRs`=5, with both write flags high.
  - Expect `forwardA`=10.
  - With `memRegWrite`=0, expect `forwardA`=01.
  - With `exRs`=0, expect 00.
- **Memory wait**: `memReq`=1 with `memReady` low for 3 cycles, then high.
  - Expect 3 frozen cycles, each with `memwbFlush`=1, and state RUN after the ready cycle.
  - Expect `stallCycles`=3.
- **Branch during wait**: `branchTaken`=1 raised in MEMWAIT.
  - Expect no flush while frozen.
  - Expect `ifidFlush`=`idexFlush`=1 in the `memReady` cycle.
- **Timeout**: TIMEOUT=4 and `memReady` held at 0.
  - Expect HALT after the 4th stall cycle, with `memError`=1 and all enables 0.
  - Deassert then reassert `resetN` mid-HALT: expect RUN, `memError`=0, `stallCycles`=0.
- **Without `HAZARD_FORWARDING_EN`**: ALU writing `$3` followed by a reader of `$3`.
  - Expect 2 stall cycles and `forwardA`/`forwardB` stuck at 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline-side inputs and register-control outputs.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUsesRt;
    logic [4:0]  exRs;
    logic [4:0]  exRt;
    logic [4:0]  exRd;
    logic        exRegWrite;
    logic        exMemRead;
    logic [4:0]  memRd;
    logic        memRegWrite;
    logic [4:0]  wbRd;
    logic        wbRegWrite;
    logic        branchTaken;
    logic        memReq;
    logic        memReady;

    logic        pcWrite;
    logic        ifidWrite;
    logic        idexWrite;
    logic        exmemWrite;
    logic        memwbWrite;
    logic        ifidFlush;
    logic        idexFlush;
    logic        memwbFlush;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic        memError;
    logic [15:0] stallCycles;

    modport master (
        output idRs, idRt, idUsesRt, exRs, exRt, exRd, exRegWrite, exMemRead,
               memRd, memRegWrite, wbRd, wbRegWrite, branchTaken, memReq, memReady,
        input  pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite,
               ifidFlush, idexFlush, memwbFlush, forwardA, forwardB,
               memError, stallCycles
    );

    modport slave (
        input  idRs, idRt, idUsesRt, exRs, exRt, exRd, exRegWrite, exMemRead,
               memRd, memRegWrite, wbRd, wbRegWrite, branchTaken, memReq, memReady,
        output pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite,
               ifidFlush, idexFlush, memwbFlush, forwardA, forwardB,
               memError, stallCycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage MIPS pipeline with a memory watchdog.
// Define HAZARD_FORWARDING_EN for EX operand forwarding; otherwise RAW hazards stall.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    resetN,
    pipeline_hazard_ctrl_if.slave   hz,
    output logic [1:0]              state_o
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_e;

    // Write-enable order: {pc, ifid, idex, exmem, memwb}; flush order: {ifid, idex, memwb}.
    localparam logic [4:0] WE_ALL  = 5'b11111;
    localparam logic [4:0] WE_LU   = 5'b00111;
    localparam logic [4:0] WE_FRZ  = 5'b00001;
    localparam logic [2:0] FL_BR   = 3'b110;
    localparam logic [2:0] FL_LU   = 3'b010;
    localparam logic [2:0] FL_FRZ  = 3'b001;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q;
    logic        mem_stall;
    logic        data_stall;
    logic [4:0]  run_we, we;
    logic [2:0]  run_flush, flush;

    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst,
                                     input logic dst_we);
        return dst_we && (dst != 5'd0) && (dst == src);
    endfunction

    assign mem_stall = hz.memReq && !hz.memReady;

`ifdef HAZARD_FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src_hit(src, hz.memRd, hz.memRegWrite))
            sel = 2'b10;
        else if (src_hit(src, hz.wbRd, hz.wbRegWrite))
            sel = 2'b01;
        return sel;
    endfunction

    assign data_stall = hz.exMemRead &&
                        (src_hit(hz.idRs, hz.exRd, hz.exRegWrite) ||
                         (hz.idUsesRt && src_hit(hz.idRt, hz.exRd, hz.exRegWrite)));
    assign hz.forwardA = fwd_sel(hz.exRs);
    assign hz.forwardB = fwd_sel(hz.exRt);
`else
    // Without forwarding, a producer in EX or MEM must drain to WB before ID may read.
    assign data_stall = src_hit(hz.idRs, hz.exRd, hz.exRegWrite) ||
                        src_hit(hz.idRs, hz.memRd, hz.memRegWrite) ||
                        (hz.idUsesRt && (src_hit(hz.idRt, hz.exRd, hz.exRegWrite) ||
                                         src_hit(hz.idRt, hz.memRd, hz.memRegWrite)));
    assign hz.forwardA = 2'b00;
    assign hz.forwardB = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.exRs, hz.exRt, hz.wbRd, hz.wbRegWrite, hz.exMemRead};
`endif

    always_comb begin
        run_we    = WE_ALL;
        run_flush = 3'b000;
        if (hz.branchTaken) begin
            run_flush = FL_BR;
        end else if (data_stall) begin
            run_we    = WE_LU;
            run_flush = FL_LU;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we         = run_we;
        flush      = run_flush;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    we         = WE_FRZ;
                    flush      = FL_FRZ;
                    state_d    = MEMWAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEMWAIT: begin
                if (!hz.memReady) begin
                    we         = WE_FRZ;
                    flush      = FL_FRZ;
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_q == 16'(TIMEOUT - 1))
                        state_d = HALT;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 16'd0;
                end
            end
            default: begin
                we    = 5'b00000;
                flush = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if ((state_q != HALT) && !we[4] && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign {hz.pcWrite, hz.ifidWrite, hz.idexWrite, hz.exmemWrite, hz.memwbWrite} = we;
    assign {hz.ifidFlush, hz.idexFlush, hz.memwbFlush} = flush;
    assign hz.memError    = (state_q == HALT);
    assign hz.stallCycles = stall_cnt_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table of single-cycle vectors plus
// multi-cycle sequences for memory wait, branch-in-wait, load-use, RAW and watchdog.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned TIMEOUT = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [4:0] WE_ALL  = 5'b11111;
  localparam logic [4:0] WE_LU   = 5'b00111;
  localparam logic [4:0] WE_FRZ  = 5'b00001;
  localparam logic [4:0] WE_NONE = 5'b00000;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_LU   = 3'b010;
  localparam logic [2:0] FL_BR   = 3'b110;
  localparam logic [2:0] FL_FRZ  = 3'b001;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       br, mreq, mrdy;
    logic [4:0] exp_we;
    logic [2:0] exp_fl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  logic        clk;
  logic        resetN;
  logic [1:0]  state_o;
  int          errors;
  int          checks;
  int          exp_stall;
  vec_t        vecs[$];
  vec_t        zero;
  vec_t        v;
  logic [11:0] exp_q[$];

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetN (resetN),
    .hz     (hz),
    .state_o(state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string name, input int id_rs, input int id_rt, input int id_u,
                              input int ex_rs, input int ex_rt, input int ex_rd, input int ex_rw,
                              input int ex_mr, input int mem_rd, input int mem_rw, input int wb_rd,
                              input int wb_rw, input int br, input int mreq, input int mrdy,
                              input logic [4:0] we, input logic [2:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t r;
    r.name = name;
    r.id_rs = 5'(id_rs); r.id_rt = 5'(id_rt); r.id_uses_rt = 1'(id_u);
    r.ex_rs = 5'(ex_rs); r.ex_rt = 5'(ex_rt); r.ex_rd = 5'(ex_rd);
    r.ex_rw = 1'(ex_rw); r.ex_mr = 1'(ex_mr);
    r.mem_rd = 5'(mem_rd); r.mem_rw = 1'(mem_rw);
    r.wb_rd = 5'(wb_rd); r.wb_rw = 1'(wb_rw);
    r.br = 1'(br); r.mreq = 1'(mreq); r.mrdy = 1'(mrdy);
    r.exp_we = we; r.exp_fl = fl; r.exp_fa = fa; r.exp_fb = fb;
    return r;
  endfunction

  // driver
  task automatic drive(input vec_t d);
    hz.idRs = d.id_rs;       hz.idRt = d.id_rt;       hz.idUsesRt = d.id_uses_rt;
    hz.exRs = d.ex_rs;       hz.exRt = d.ex_rt;       hz.exRd = d.ex_rd;
    hz.exRegWrite = d.ex_rw; hz.exMemRead = d.ex_mr;
    hz.memRd = d.mem_rd;     hz.memRegWrite = d.mem_rw;
    hz.wbRd = d.wb_rd;       hz.wbRegWrite = d.wb_rw;
    hz.branchTaken = d.br;   hz.memReq = d.mreq;      hz.memReady = d.mrdy;
  endtask

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
    end
  endtask

  function automatic logic [4:0] we_now();
    return {hz.pcWrite, hz.ifidWrite, hz.idexWrite, hz.exmemWrite, hz.memwbWrite};
  endfunction

  function automatic logic [2:0] fl_now();
    return {hz.ifidFlush, hz.idexFlush, hz.memwbFlush};
  endfunction

  task automatic chk_ctl(input string tag, input logic [4:0] we, input logic [2:0] fl);
    chk({tag, "_we"}, 32'(we_now()), 32'(we));
    chk({tag, "_flush"}, 32'(fl_now()), 32'(fl));
  endtask

  task automatic step(input vec_t d);
    @(negedge clk);
    drive(d);
    #2;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_stall = 0;
    zero = mk("zero", 0,0,0, 0,0,0,0,0, 0,0, 0,0, 0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00);
    resetN = 1'b0;
    drive(zero);
    #2;
    chk("reset_state", 32'(state_o), 32'(S_RUN));
    chk("reset_memError", 32'(hz.memError), 32'd0);
    chk("reset_stallCycles", 32'(hz.stallCycles), 32'd0);
    chk_ctl("reset", WE_ALL, FL_NONE);
    @(negedge clk);
    resetN = 1'b1;

    //        name           idRs idRt u  exRs exRt exRd rw mr memRd rw wbRd rw br rq rdy
    vecs.push_back(mk("idle",         0,0,0,  0,0,0,0,0,  0,0,  0,0,  0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00));
    vecs.push_back(mk("lu_rt",        0,9,1,  0,0,9,1,1,  0,0,  0,0,  0,0,0, WE_LU,  FL_LU,   2'b00, 2'b00));
    vecs.push_back(mk("lu_rt_unused", 0,9,0,  0,0,9,1,1,  0,0,  0,0,  0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00));
    vecs.push_back(mk("lu_r0",        0,0,1,  0,0,0,1,1,  0,0,  0,0,  0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00));
    vecs.push_back(mk("br_over_lu",   8,0,0,  0,0,8,1,1,  0,0,  0,0,  1,0,0, WE_ALL, FL_BR,   2'b00, 2'b00));
    vecs.push_back(mk("raw_ex",       3,0,0,  0,0,3,1,0,  0,0,  0,0,  0,0,0,
                      FWD ? WE_ALL : WE_LU, FWD ? FL_NONE : FL_LU, 2'b00, 2'b00));
    vecs.push_back(mk("raw_mem",      3,0,0,  0,0,0,0,0,  3,1,  0,0,  0,0,0,
                      FWD ? WE_ALL : WE_LU, FWD ? FL_NONE : FL_LU, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_both",     0,0,0,  5,0,0,0,0,  5,1,  5,1,  0,0,0,
                      WE_ALL, FL_NONE, FWD ? 2'b10 : 2'b00, 2'b00));
    vecs.push_back(mk("fwd_wb",       0,0,0,  5,0,0,0,0,  5,0,  5,1,  0,0,0,
                      WE_ALL, FL_NONE, FWD ? 2'b01 : 2'b00, 2'b00));
    vecs.push_back(mk("fwd_r0",       0,0,0,  0,0,0,0,0,  0,1,  0,1,  0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_b_wb",     0,0,0,  0,6,0,0,0,  7,1,  6,1,  0,0,0,
                      WE_ALL, FL_NONE, 2'b00, FWD ? 2'b01 : 2'b00));
    vecs.push_back(mk("mem_ready_0",  0,0,0,  0,0,0,0,0,  0,0,  0,0,  0,1,1, WE_ALL, FL_NONE, 2'b00, 2'b00));
    vecs.push_back(mk("fwd_ab_mem",   0,0,0,  4,4,0,0,0,  4,1,  0,0,  0,0,0,
                      WE_ALL, FL_NONE, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00));
    vecs.push_back(mk("fwd_wb_nowr",  0,0,0,  5,0,0,0,0,  0,0,  5,0,  0,0,0, WE_ALL, FL_NONE, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      step(vecs[i]);
      exp_q.push_back({vecs[i].exp_we, vecs[i].exp_fl, vecs[i].exp_fa, vecs[i].exp_fb});
      if (vecs[i].exp_we[4] == 1'b0) exp_stall++;
      chk(vecs[i].name, 32'({we_now(), fl_now(), hz.forwardA, hz.forwardB}), 32'(exp_q.pop_front()));
    end
    step(zero);
    chk("table_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));

    // memory wait: 3 frozen cycles, then ready
    v = zero; v.mreq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(v);
      chk_ctl($sformatf("memwait_frz%0d", k), WE_FRZ, FL_FRZ);
      chk($sformatf("memwait_state%0d", k), 32'(state_o), 32'(k == 0 ? S_RUN : S_WAIT));
    end
    v.mrdy = 1'b1;
    step(v);
    chk_ctl("memwait_ready", WE_ALL, FL_NONE);
    exp_stall += 3;
    step(zero);
    chk("memwait_state_run", 32'(state_o), 32'(S_RUN));
    chk("memwait_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));

    // branch raised while frozen is acted on in the ready cycle
    v = zero; v.mreq = 1'b1;
    step(v);
    chk_ctl("brwait_enter", WE_FRZ, FL_FRZ);
    v.br = 1'b1;
    step(v);
    chk_ctl("brwait_frozen", WE_FRZ, FL_FRZ);
    chk("brwait_state", 32'(state_o), 32'(S_WAIT));
    v.mrdy = 1'b1;
    step(v);
    chk_ctl("brwait_ready", WE_ALL, FL_BR);
    exp_stall += 2;
    step(zero);
    chk("brwait_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));

    // load-use: lw $t0 in EX, add reading $t0 in ID
    v = zero; v.ex_mr = 1'b1; v.ex_rw = 1'b1; v.ex_rd = 5'd8; v.id_rs = 5'd8;
    step(v);
    chk_ctl("loaduse", WE_LU, FL_LU);
    exp_stall++;
    v = zero; v.id_rs = 5'd8; v.mem_rd = 5'd8; v.mem_rw = 1'b1;
    step(v);
    chk_ctl("loaduse_after", FWD ? WE_ALL : WE_LU, FWD ? FL_NONE : FL_LU);
    chk("loaduse_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));
    if (!FWD) exp_stall++;

    // ALU writes $3, next instruction reads $3
    v = zero; v.ex_rd = 5'd3; v.ex_rw = 1'b1; v.id_rs = 5'd3;
    step(v);
    chk_ctl("raw_c1", FWD ? WE_ALL : WE_LU, FWD ? FL_NONE : FL_LU);
    v = zero; v.mem_rd = 5'd3; v.mem_rw = 1'b1; v.id_rs = 5'd3;
    step(v);
    chk_ctl("raw_c2", FWD ? WE_ALL : WE_LU, FWD ? FL_NONE : FL_LU);
    v = zero; v.wb_rd = 5'd3; v.wb_rw = 1'b1; v.id_rs = 5'd3; v.ex_rs = 5'd3; v.ex_rt = 5'd3;
    step(v);
    chk_ctl("raw_c3", WE_ALL, FL_NONE);
    chk("raw_fwdA", 32'(hz.forwardA), 32'(FWD ? 2'b01 : 2'b00));
    chk("raw_fwdB", 32'(hz.forwardB), 32'(FWD ? 2'b01 : 2'b00));
    if (!FWD) exp_stall += 2;
    step(zero);
    chk("raw_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));

    // watchdog: memory never answers
    v = zero; v.mreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(v);
      chk_ctl($sformatf("timeout_frz%0d", k), WE_FRZ, FL_FRZ);
      chk($sformatf("timeout_state%0d", k), 32'(state_o), 32'(k == 0 ? S_RUN : S_WAIT));
    end
    exp_stall += 4;
    step(v);
    chk("halt_state", 32'(state_o), 32'(S_HALT));
    chk("halt_memError", 32'(hz.memError), 32'd1);
    chk_ctl("halt", WE_NONE, FL_NONE);
    step(v);
    step(v);
    chk("halt_hold_state", 32'(state_o), 32'(S_HALT));
    chk("halt_stallCycles", 32'(hz.stallCycles), 32'(exp_stall));
    @(negedge clk);
    resetN = 1'b0;
    #2;
    chk("halt_rst_state", 32'(state_o), 32'(S_RUN));
    chk("halt_rst_memError", 32'(hz.memError), 32'd0);
    chk("halt_rst_stallCycles", 32'(hz.stallCycles), 32'd0);
    chk_ctl("halt_rst_decode", WE_FRZ, FL_FRZ);
    @(negedge clk);
    resetN = 1'b1;
    drive(zero);
    #2;
    chk_ctl("post_rst", WE_ALL, FL_NONE);
    step(zero);
    chk("post_rst_state", 32'(state_o), 32'(S_RUN));
    chk("post_rst_stallCycles", 32'(hz.stallCycles), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
